// File: rtl/hwag_pkg.sv
// Shared types and widths for the hwag capture-input conditioning path.
package hwag_pkg;

    typedef enum logic [1:0] {
        LOW   = 2'd0,
        HIGH  = 2'd1,
        SUPPR = 2'd2
    } cap_state_t;

    localparam int CAP_PERIOD_W = 24;
    localparam int REJECT_W     = 8;

endpackage

// File: rtl/cap_sync_filter.sv
// Synchronises the raw VR comparator output, normalises polarity so the tooth
// edge is always 0->1, and only moves the filtered level after a stable run.
module cap_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter bit ACTIVE_FALL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic vr_in_i,
    output logic filt_o
);

    localparam int RUN_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILT_LEN - 1);
    localparam logic [SYNC_STAGES-1:0] SYNC_IDLE = {SYNC_STAGES{ACTIVE_FALL}};

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [RUN_W-1:0]       run_q, run_d;
    logic                   filt_q, filt_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1] ^ ACTIVE_FALL;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], vr_in_i};
        filt_d = filt_q;
        run_d  = '0;
        // The run length restarts whenever the input agrees with the filtered level.
        if (s != filt_q) begin
            if (run_q == RUN_LAST) begin
                filt_d = ~filt_q;
            end else begin
                run_d = run_q + RUN_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= SYNC_IDLE;
            run_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            run_q  <= run_d;
            filt_q <= filt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/hwag_cap_filter.sv
// VR crank input conditioner: clean active-high tooth level for hwag.cap, with
// early-edge blanking, tooth-period measurement and a rejected-edge counter.
module hwag_cap_filter
    import hwag_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int PERIOD_W    = CAP_PERIOD_W,
    parameter int BLANK_SHIFT = 2,
    parameter bit ACTIVE_FALL = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                vr_in_i,
    input  logic                clr_reject_i,
    output logic                cap_o,
    output logic                cap_edge_o,
    output logic [PERIOD_W-1:0] period_o,
    output logic                period_valid_o,
    output logic [REJECT_W-1:0] reject_cnt_o
);

    localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
    localparam logic [REJECT_W-1:0] REJ_MAX = '1;

    cap_state_t          state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                valid_q, valid_d;
    logic                seen_q, seen_d;
    logic                cap_q, cap_d;
    logic                edge_q, edge_d;
    logic [REJECT_W-1:0] rej_q, rej_d;
    logic                filt;
    logic                cnt_sat;
    logic                blank;
    logic                accept;
    logic                reject;

    cap_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN),
        .ACTIVE_FALL (ACTIVE_FALL)
    ) u_sync_filter (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .vr_in_i (vr_in_i),
        .filt_o  (filt)
    );

    assign cnt_sat = (cnt_q == CNT_MAX);
    assign blank   = valid_q && (cnt_q < (period_q >> BLANK_SHIFT));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_sat ? cnt_q : cnt_q + PERIOD_W'(1);
        period_d = period_q;
        valid_d  = valid_q;
        seen_d   = seen_q;
        cap_d    = cap_q;
        edge_d   = 1'b0;
        rej_d    = rej_q;
        accept   = 1'b0;
        reject   = 1'b0;

        // SUPPR swallows the whole rejected pulse so cap never shows it.
        case (state_q)
            LOW: begin
                if (filt) begin
                    if (blank) begin
                        state_d = SUPPR;
                        reject  = 1'b1;
                    end else begin
                        state_d = HIGH;
                        accept  = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (!filt) begin
                    state_d = LOW;
                    cap_d   = 1'b0;
                end
            end
            SUPPR: begin
                if (!filt) begin
                    state_d = LOW;
                end
            end
            default: state_d = LOW;
        endcase

        // A saturated counter means the wheel stalled: the next edge starts a fresh measurement.
        if (accept) begin
            cap_d    = 1'b1;
            edge_d   = 1'b1;
            period_d = cnt_q;
            valid_d  = seen_q && !cnt_sat;
            seen_d   = 1'b1;
            cnt_d    = PERIOD_W'(1);
        end else if (cnt_sat) begin
            valid_d = 1'b0;
            seen_d  = 1'b0;
        end

        if (clr_reject_i) begin
            rej_d = '0;
        end else if (reject && (rej_q != REJ_MAX)) begin
            rej_d = rej_q + REJECT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= LOW;
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            seen_q   <= 1'b0;
            cap_q    <= 1'b0;
            edge_q   <= 1'b0;
            rej_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            seen_q   <= seen_d;
            cap_q    <= cap_d;
            edge_q   <= edge_d;
            rej_q    <= rej_d;
        end
    end

    assign cap_o          = cap_q;
    assign cap_edge_o     = edge_q;
    assign period_o       = period_q;
    assign period_valid_o = valid_q;
    assign reject_cnt_o   = rej_q;

endmodule
